hazard_ctrl: RTL and testbench

- Pipeline control unit that drives the enable and flush inputs of the PC, IF/ID and ID/EX pipeline registers. It is the master side of the en/flush interface those registers consume.
- Sequences the post-reset start flush, load-use stalls, branch/jump flushes and a multi-cycle MULT/DIV busy window.
- Sits beside the decode stage. It observes ID-stage register sources and the ID/EX register outputs now in EX.

---
 rtl/hazard_ctrl.sv | 96 +++++++++
 tb/tb_hazard_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: drives en/flush of the PC, IF/ID and ID/EX registers,
// sequencing the start flush, load-use stalls, branch/jump flushes and the MULT/DIV busy window.
module hazard_ctrl #(
  parameter int START_FLUSH_CYCLES = 2,
  parameter int MDU_CYCLES         = 32,
  parameter int CNT_W              = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] ID_Rs,
  input  logic [4:0] ID_Rt,
  input  logic       ID_UsesRs,
  input  logic       ID_UsesRt,
  input  logic       ID_UsesHiLo,
  input  logic       ID_Jump,
  input  logic       EX_DMemRead,
  input  logic [4:0] EX_RegWtaddr,
  input  logic       EX_BranchTaken,
  input  logic       EX_MDUStart,
  output logic       PC_en,
  output logic       IFID_en,
  output logic       IFID_flush,
  output logic       IDEX_en,
  output logic       IDEX_flush,
  output logic       MDU_busy,
  output logic       start_done
);

  typedef enum logic [1:0] {
    START = 2'd0,
    RUN   = 2'd1,
    MDU   = 2'd2
  } stateT;

  stateT            state;
  logic [CNT_W-1:0] cnt;
  logic             loadUse;
  logic             hiLoStall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= START;
      cnt   <= CNT_W'(START_FLUSH_CYCLES - 1);
    end else begin
      case (state)
        START: begin
          if (cnt == '0) state <= RUN;
          else           cnt   <= cnt - CNT_W'(1);
        end
        RUN, MDU: begin
          // A new start always (re)loads the window, even under a branch flush.
          if (EX_MDUStart) begin
            cnt   <= CNT_W'(MDU_CYCLES - 2);
            state <= MDU;
          end else if (state == MDU) begin
            if (cnt == '0) state <= RUN;
            else           cnt   <= cnt - CNT_W'(1);
          end
        end
        default: state <= START;
      endcase
    end
  end

  assign loadUse = EX_DMemRead && (EX_RegWtaddr != 5'd0) &&
                   ((ID_UsesRs && (ID_Rs == EX_RegWtaddr)) ||
                    (ID_UsesRt && (ID_Rt == EX_RegWtaddr)));
  assign hiLoStall = (state == MDU) && ID_UsesHiLo;

  // en=1 lets a register capture its input this cycle; flush=1 makes it capture a bubble
  // instead. Consumers obey flush whenever en is high; there is no back-pressure path.
  always_comb begin
    PC_en      = 1'b1;
    IFID_en    = 1'b1;
    IFID_flush = 1'b0;
    IDEX_en    = 1'b1;
    IDEX_flush = 1'b0;
    MDU_busy   = (state == MDU);
    start_done = (state != START);
    if (state == START) begin
      PC_en      = 1'b0;
      IFID_flush = 1'b1;
      IDEX_flush = 1'b1;
    end else if (EX_BranchTaken) begin
      IFID_flush = 1'b1;
      IDEX_flush = 1'b1;
    end else if (hiLoStall || loadUse) begin
      PC_en      = 1'b0;
      IFID_en    = 1'b0;
      IDEX_flush = 1'b1;
    end else if (ID_Jump) begin
      IFID_flush = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: start flush, load-use, branch/jump priority,
// MDU busy window with HiLo stall, and reset during an MDU window.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] ID_Rs, ID_Rt, EX_RegWtaddr;
  logic       ID_UsesRs, ID_UsesRt, ID_UsesHiLo, ID_Jump;
  logic       EX_DMemRead, EX_BranchTaken, EX_MDUStart;
  logic       PC_en, IFID_en, IFID_flush, IDEX_en, IDEX_flush, MDU_busy, start_done;

  int tests  = 0;
  int failed = 0;

  hazard_ctrl #(
    .START_FLUSH_CYCLES(2),
    .MDU_CYCLES        (32),
    .CNT_W             (6)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ID_Rs         (ID_Rs),
    .ID_Rt         (ID_Rt),
    .ID_UsesRs     (ID_UsesRs),
    .ID_UsesRt     (ID_UsesRt),
    .ID_UsesHiLo   (ID_UsesHiLo),
    .ID_Jump       (ID_Jump),
    .EX_DMemRead   (EX_DMemRead),
    .EX_RegWtaddr  (EX_RegWtaddr),
    .EX_BranchTaken(EX_BranchTaken),
    .EX_MDUStart   (EX_MDUStart),
    .PC_en         (PC_en),
    .IFID_en       (IFID_en),
    .IFID_flush    (IFID_flush),
    .IDEX_en       (IDEX_en),
    .IDEX_flush    (IDEX_flush),
    .MDU_busy      (MDU_busy),
    .start_done    (start_done)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clearInputs();
    ID_Rs = 5'd0; ID_Rt = 5'd0; EX_RegWtaddr = 5'd0;
    ID_UsesRs = 1'b0; ID_UsesRt = 1'b0; ID_UsesHiLo = 1'b0; ID_Jump = 1'b0;
    EX_DMemRead = 1'b0; EX_BranchTaken = 1'b0; EX_MDUStart = 1'b0;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Compares every output; expected order: PC_en IFID_en IFID_flush IDEX_en IDEX_flush MDU_busy start_done
  task automatic checkOuts(input string tag, input logic [6:0] exp);
    #1;
    chk({tag, ".PC_en"},      PC_en,      exp[6]);
    chk({tag, ".IFID_en"},    IFID_en,    exp[5]);
    chk({tag, ".IFID_flush"}, IFID_flush, exp[4]);
    chk({tag, ".IDEX_en"},    IDEX_en,    exp[3]);
    chk({tag, ".IDEX_flush"}, IDEX_flush, exp[2]);
    chk({tag, ".MDU_busy"},   MDU_busy,   exp[1]);
    chk({tag, ".start_done"}, start_done, exp[0]);
  endtask

  localparam logic [6:0] START_V  = 7'b0_1_1_1_1_0_0;
  localparam logic [6:0] RUN_V    = 7'b1_1_0_1_0_0_1;
  localparam logic [6:0] STALL_V  = 7'b0_0_0_1_1_0_1;
  localparam logic [6:0] BRANCH_V = 7'b1_1_1_1_1_0_1;
  localparam logic [6:0] JUMP_V   = 7'b1_1_1_1_0_0_1;
  localparam logic [6:0] MSTALL_V = 7'b0_0_0_1_1_1_1;
  localparam logic [6:0] MRUN_V   = 7'b1_1_0_1_0_1_1;

  initial begin
    rst_n = 1'b0;
    clearInputs();

    // Reset and start flush
    checkOuts("in_reset", START_V);
    tick();
    tick();
    rst_n = 1'b1;
    checkOuts("start_c1", START_V);
    tick();
    checkOuts("start_c2", START_V);
    tick();
    checkOuts("run_first", RUN_V);

    // Load-use
    EX_DMemRead = 1'b1; EX_RegWtaddr = 5'd8; ID_UsesRs = 1'b1; ID_Rs = 5'd8;
    checkOuts("loaduse_rs", STALL_V);
    EX_RegWtaddr = 5'd0; ID_Rs = 5'd0;
    checkOuts("loaduse_r0", RUN_V);
    EX_RegWtaddr = 5'd8; ID_Rs = 5'd8; ID_UsesRs = 1'b0;
    checkOuts("loaduse_nouse", RUN_V);
    ID_UsesRt = 1'b1; ID_Rt = 5'd8;
    checkOuts("loaduse_rt", STALL_V);
    EX_DMemRead = 1'b0;
    checkOuts("noload", RUN_V);
    EX_DMemRead = 1'b1; ID_Rt = 5'd9;
    checkOuts("rt_differs", RUN_V);
    ID_Rt = 5'd8;

    // Branch overrides load-use; jump alone; jump suppressed by stall
    EX_BranchTaken = 1'b1;
    checkOuts("branch_over_stall", BRANCH_V);
    clearInputs();
    ID_Jump = 1'b1;
    checkOuts("jump_alone", JUMP_V);
    EX_DMemRead = 1'b1; EX_RegWtaddr = 5'd3; ID_UsesRs = 1'b1; ID_Rs = 5'd3;
    checkOuts("jump_under_stall", STALL_V);
    clearInputs();
    tick();

    // MDU window with HiLo stall held
    EX_MDUStart = 1'b1;
    checkOuts("mdu_ex_cycle", RUN_V);
    tick();
    EX_MDUStart = 1'b0; ID_UsesHiLo = 1'b1;
    for (int i = 0; i < 31; i++) begin
      checkOuts($sformatf("mdu_stall_%0d", i), MSTALL_V);
      tick();
    end
    checkOuts("mdu_release", RUN_V);
    clearInputs();
    tick();

    // Branch together with MDU start: flush applies, count still loads
    EX_BranchTaken = 1'b1; EX_MDUStart = 1'b1;
    checkOuts("branch_mdustart", BRANCH_V);
    tick();
    clearInputs();
    checkOuts("mdu_after_branch", MRUN_V);
    ID_UsesHiLo = 1'b1; EX_BranchTaken = 1'b1;
    checkOuts("branch_over_hilo", 7'b1_1_1_1_1_1_1);
    clearInputs();
    for (int i = 0; i < 9; i++) tick();
    checkOuts("mdu_10_in", MRUN_V);

    // Reset mid-MDU: START values at once, hazard inputs ignored
    rst_n = 1'b0;
    EX_BranchTaken = 1'b1; ID_Jump = 1'b1;
    checkOuts("reset_mid_mdu", START_V);
    tick();
    rst_n = 1'b1;
    checkOuts("restart_c1", START_V);
    tick();
    checkOuts("restart_c2", START_V);
    tick();
    clearInputs();
    checkOuts("restart_run", RUN_V);
    tick();
    checkOuts("restart_run_idle", RUN_V);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
